mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 227 ++++++++++++++++++++++
 tb/tb_mem_stage.sv | 448 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// mem_stage : RV32I memory-access pipeline stage (load/store bus FSM, branch
//             resolution, MEM/WB register).           Rev 1.0
// ============================================================================

module mem_stage #(
    parameter int XLEN    = 32,
    parameter int RD_W    = 5,
    parameter int WB_W    = 2,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic [2:0]        mem_ctrl,
    input  logic [2:0]        funct3,
    input  logic [WB_W-1:0]   wb_ctrl_in,
    input  logic [XLEN-1:0]   alu_result,
    input  logic [XLEN-1:0]   store_data,
    input  logic              zero_in,
    input  logic              lt_in,
    input  logic              ltu_in,
    input  logic [RD_W-1:0]   rd_in,
    output logic              mem_stall,
    output logic              branch_taken,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [XLEN-1:0]   dmem_addr,
    output logic [XLEN/8-1:0] dmem_be,
    output logic [XLEN-1:0]   dmem_wdata,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    input  logic [XLEN-1:0]   dmem_rdata,
    output logic              wb_valid,
    output logic              wb_err,
    output logic [WB_W-1:0]   wb_ctrl,
    output logic [XLEN-1:0]   wb_alu,
    output logic [XLEN-1:0]   wb_rdata,
    output logic [RD_W-1:0]   wb_rd
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [7:0] C_CNT_LAST = 8'(TIMEOUT - 1);

    state_t            r_state;
    logic [7:0]        r_cnt;
    logic [2:0]        r_funct3;
    logic [XLEN-1:0]   r_addr;
    logic [WB_W-1:0]   r_wb_ctrl;
    logic [RD_W-1:0]   r_rd;

    logic              w_memwrite;
    logic              w_memread;
    logic              w_is_mem;
    logic              w_bad_f3;
    logic              w_misalign;
    logic              w_illegal;
    logic              w_accept;
    logic              w_cond;
    logic [XLEN/8-1:0] w_st_be;
    logic [XLEN-1:0]   w_st_wdata;
    logic [XLEN-1:0]   w_ld_shift;
    logic [XLEN-1:0]   w_ld_data;

    assign w_memwrite = mem_ctrl[2];
    assign w_memread  = mem_ctrl[1];
    assign w_is_mem   = w_memwrite | w_memread;
    assign w_bad_f3   = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
    assign w_misalign = ((funct3[1:0] == 2'b01) && alu_result[0]) ||
                        ((funct3[1:0] == 2'b10) && (alu_result[1:0] != 2'b00));
    assign w_illegal  = w_is_mem && ((w_memwrite && w_memread) || w_bad_f3 || w_misalign);
    assign w_accept   = ex_valid && w_is_mem && !w_illegal;

    assign mem_stall    = (r_state != IDLE) || w_accept;
    assign branch_taken = ex_valid & mem_ctrl[0] & w_cond;

    always_comb begin
        w_cond = 1'b0;
        case (funct3)
            3'b000:  w_cond = zero_in;
            3'b001:  w_cond = !zero_in;
            3'b100:  w_cond = lt_in;
            3'b101:  w_cond = !lt_in;
            3'b110:  w_cond = ltu_in;
            3'b111:  w_cond = !ltu_in;
            default: w_cond = 1'b0;
        endcase
    end

    // Sub-word stores replicate the datum across lanes; the byte enables pick the lane.
    always_comb begin
        w_st_be    = 4'b1111;
        w_st_wdata = store_data;
        case (funct3[1:0])
            2'b00: begin
                w_st_be    = 4'b0001 << alu_result[1:0];
                w_st_wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                w_st_be    = 4'b0011 << {alu_result[1], 1'b0};
                w_st_wdata = {2{store_data[15:0]}};
            end
            default: ;
        endcase
    end

    assign w_ld_shift = dmem_rdata >> {r_addr[1:0], 3'b000};

    always_comb begin
        w_ld_data = w_ld_shift;
        case (r_funct3)
            3'b000:  w_ld_data = {{24{w_ld_shift[7]}}, w_ld_shift[7:0]};
            3'b001:  w_ld_data = {{16{w_ld_shift[15]}}, w_ld_shift[15:0]};
            3'b100:  w_ld_data = {24'b0, w_ld_shift[7:0]};
            3'b101:  w_ld_data = {16'b0, w_ld_shift[15:0]};
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= 8'd0;
            r_funct3   <= 3'd0;
            r_addr     <= '0;
            r_wb_ctrl  <= '0;
            r_rd       <= '0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_be    <= '0;
            dmem_wdata <= '0;
            wb_valid   <= 1'b0;
            wb_err     <= 1'b0;
            wb_ctrl    <= '0;
            wb_alu     <= '0;
            wb_rdata   <= '0;
            wb_rd      <= '0;
        end else begin
            wb_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_funct3   <= funct3;
                        r_addr     <= alu_result;
                        r_wb_ctrl  <= wb_ctrl_in;
                        r_rd       <= rd_in;
                        r_cnt      <= 8'd0;
                        dmem_req   <= 1'b1;
                        dmem_we    <= w_memwrite;
                        dmem_addr  <= {alu_result[XLEN-1:2], 2'b00};
                        dmem_be    <= w_memwrite ? w_st_be : 4'b1111;
                        dmem_wdata <= w_memwrite ? w_st_wdata : '0;
                        r_state    <= REQ;
                    end else if (ex_valid) begin
                        // Non-memory and illegal ops retire straight from the EX/MEM slot.
                        wb_valid <= 1'b1;
                        wb_err   <= w_illegal;
                        wb_ctrl  <= w_illegal ? '0 : wb_ctrl_in;
                        wb_alu   <= alu_result;
                        wb_rdata <= '0;
                        wb_rd    <= rd_in;
                    end
                end
                REQ: begin
                    if (dmem_gnt) begin
                        dmem_req <= 1'b0;
                        r_cnt    <= 8'd0;
                        if (dmem_we) begin
                            wb_valid <= 1'b1;
                            wb_err   <= 1'b0;
                            wb_ctrl  <= r_wb_ctrl;
                            wb_alu   <= r_addr;
                            wb_rdata <= '0;
                            wb_rd    <= r_rd;
                            r_state  <= IDLE;
                        end else begin
                            r_state  <= RESP;
                        end
                    end else if (r_cnt == C_CNT_LAST) begin
                        dmem_req <= 1'b0;
                        wb_valid <= 1'b1;
                        wb_err   <= 1'b1;
                        wb_ctrl  <= '0;
                        wb_alu   <= r_addr;
                        wb_rdata <= '0;
                        wb_rd    <= r_rd;
                        r_state  <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                RESP: begin
                    if (dmem_rvalid) begin
                        wb_valid <= 1'b1;
                        wb_err   <= 1'b0;
                        wb_ctrl  <= r_wb_ctrl;
                        wb_alu   <= r_addr;
                        wb_rdata <= w_ld_data;
                        wb_rd    <= r_rd;
                        r_state  <= IDLE;
                    end else if (r_cnt == C_CNT_LAST) begin
                        wb_valid <= 1'b1;
                        wb_err   <= 1'b1;
                        wb_ctrl  <= '0;
                        wb_alu   <= r_addr;
                        wb_rdata <= '0;
                        wb_rd    <= r_rd;
                        r_state  <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// tb_mem_stage : randomized scoreboard bench for mem_stage.   Rev 1.0
// ============================================================================

module tb_mem_stage;

    localparam int C_TIMEOUT = 4;

    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic [2:0]  mem_ctrl;
    logic [2:0]  funct3;
    logic [1:0]  wb_ctrl_in;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic        zero_in;
    logic        lt_in;
    logic        ltu_in;
    logic [4:0]  rd_in;
    logic        mem_stall;
    logic        branch_taken;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic        wb_err;
    logic [1:0]  wb_ctrl;
    logic [31:0] wb_alu;
    logic [31:0] wb_rdata;
    logic [4:0]  wb_rd;

    mem_stage #(
        .XLEN    (32),
        .RD_W    (5),
        .WB_W    (2),
        .TIMEOUT (C_TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ex_valid     (ex_valid),
        .mem_ctrl     (mem_ctrl),
        .funct3       (funct3),
        .wb_ctrl_in   (wb_ctrl_in),
        .alu_result   (alu_result),
        .store_data   (store_data),
        .zero_in      (zero_in),
        .lt_in        (lt_in),
        .ltu_in       (ltu_in),
        .rd_in        (rd_in),
        .mem_stall    (mem_stall),
        .branch_taken (branch_taken),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_be      (dmem_be),
        .dmem_wdata   (dmem_wdata),
        .dmem_gnt     (dmem_gnt),
        .dmem_rvalid  (dmem_rvalid),
        .dmem_rdata   (dmem_rdata),
        .wb_valid     (wb_valid),
        .wb_err       (wb_err),
        .wb_ctrl      (wb_ctrl),
        .wb_alu       (wb_alu),
        .wb_rdata     (wb_rdata),
        .wb_rd        (wb_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        err;
        logic [1:0]  ctrl;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [4:0]  rd;
        int          due;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: instruction semantics from the ISA rules, in plain arithmetic.
    function automatic logic ref_illegal(input logic [2:0] mc, input logic [2:0] f3,
                                         input logic [31:0] a);
        int nb;
        if (!mc[1] && !mc[2]) return 1'b0;
        if (mc[1] && mc[2]) return 1'b1;
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
        nb = 1 << (int'(f3) % 4);
        return (a % nb) != 0;
    endfunction

    function automatic logic ref_branch(input logic [2:0] mc, input logic [2:0] f3,
                                        input logic z, input logic l, input logic lu);
        if (!mc[0]) return 1'b0;
        case (f3)
            3'd0:    return z;
            3'd1:    return !z;
            3'd4:    return l;
            3'd5:    return !l;
            3'd6:    return lu;
            3'd7:    return !lu;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] a);
        int nb;
        int off;
        nb  = 1 << (int'(f3) % 4);
        off = int'(a % 4);
        return 4'(((1 << nb) - 1) << off);
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
        int     nb;
        longint mask;
        longint w;
        nb   = 1 << (int'(f3) % 4);
        mask = (longint'(1) << (8 * nb)) - 1;
        w    = 0;
        for (int i = 0; i < 4 / nb; i++) w = w | ((longint'(d) & mask) << (8 * nb * i));
        return w[31:0];
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] d);
        int     nb;
        int     off;
        longint v;
        nb  = 1 << (int'(f3) % 4);
        off = int'(a % 4);
        v   = (longint'(d) >> (8 * off)) % (longint'(1) << (8 * nb));
        if (f3 < 3'd4 && nb < 4 && v >= (longint'(1) << (8 * nb - 1)))
            v = v - (longint'(1) << (8 * nb));
        return v[31:0];
    endfunction

    // Monitor: every wb_valid pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (wb_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_wb: got wb_valid=1 expected no retirement (cycle %0d)", cyc);
            end else begin
                e = exp_q.pop_front();
                chk("wb_cycle", 32'(cyc), 32'(e.due));
                chk("wb_err",   32'(wb_err),  32'(e.err));
                chk("wb_ctrl",  32'(wb_ctrl), 32'(e.ctrl));
                chk("wb_alu",   wb_alu,       e.alu);
                chk("wb_rdata", wb_rdata,     e.rdata);
                chk("wb_rd",    32'(wb_rd),   32'(e.rd));
            end
        end
    end

    task automatic scramble();
        mem_ctrl   = 3'($urandom);
        funct3     = 3'($urandom);
        wb_ctrl_in = 2'($urandom);
        alu_result = $urandom;
        store_data = $urandom;
        zero_in    = 1'($urandom);
        lt_in      = 1'($urandom);
        ltu_in     = 1'($urandom);
        rd_in      = 5'($urandom);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_stall"},    32'(mem_stall),  32'd0);
        chk({tag, "_req"},      32'(dmem_req),   32'd0);
        chk({tag, "_we"},       32'(dmem_we),    32'd0);
        chk({tag, "_be"},       32'(dmem_be),    32'd0);
        chk({tag, "_wdata"},    dmem_wdata,      32'd0);
        chk({tag, "_wb_valid"}, 32'(wb_valid),   32'd0);
        chk({tag, "_wb_err"},   32'(wb_err),     32'd0);
        chk({tag, "_wb_ctrl"},  32'(wb_ctrl),    32'd0);
        chk({tag, "_wb_alu"},   wb_alu,          32'd0);
        chk({tag, "_wb_rdata"}, wb_rdata,        32'd0);
        chk({tag, "_wb_rd"},    32'(wb_rd),      32'd0);
    endtask

    task automatic idle_cycle();
        ex_valid = 1'b0;
        scramble();
        dmem_gnt    = 1'($urandom);
        dmem_rvalid = 1'($urandom);
        dmem_rdata  = $urandom;
        @(negedge clk);
        chk("idle_stall",  32'(mem_stall),    32'd0);
        chk("idle_branch", 32'(branch_taken), 32'd0);
        chk("idle_req",    32'(dmem_req),     32'd0);
        @(posedge clk); #1;
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
    endtask

    // One instruction through the EX/MEM slot. n_wait/r_wait >= C_TIMEOUT means no response.
    task automatic issue(input logic [2:0] mc, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] sd, input logic [1:0] wbc, input logic [4:0] rdi,
                         input logic z, input logic l, input logic lu,
                         input int n_wait, input int r_wait, input logic [31:0] rdat);
        exp_t e;
        logic mem;
        logic ill;
        logic ld;
        int   c0;
        mem = mc[1] | mc[2];
        ill = ref_illegal(mc, f3, a);
        ld  = mc[1];
        c0  = cyc;
        ex_valid   = 1'b1;
        mem_ctrl   = mc;
        funct3     = f3;
        alu_result = a;
        store_data = sd;
        wb_ctrl_in = wbc;
        rd_in      = rdi;
        zero_in    = z;
        lt_in      = l;
        ltu_in     = lu;
        e.alu   = a;
        e.rd    = rdi;
        e.err   = 1'b0;
        e.ctrl  = wbc;
        e.rdata = 32'd0;
        if (!mem || ill) begin
            e.err = ill;
            if (ill) e.ctrl = 2'd0;
            e.due = c0 + 1;
        end else if (n_wait >= C_TIMEOUT) begin
            e.err  = 1'b1;
            e.ctrl = 2'd0;
            e.due  = c0 + C_TIMEOUT + 1;
        end else if (!ld) begin
            e.due = c0 + 2 + n_wait;
        end else if (r_wait >= C_TIMEOUT) begin
            e.err  = 1'b1;
            e.ctrl = 2'd0;
            e.due  = c0 + 2 + n_wait + C_TIMEOUT;
        end else begin
            e.rdata = ref_load(f3, a, rdat);
            e.due   = c0 + 3 + n_wait + r_wait;
        end
        exp_q.push_back(e);

        @(negedge clk);
        chk("issue_stall",  32'(mem_stall),    32'(mem && !ill));
        chk("branch_taken", 32'(branch_taken), 32'(ref_branch(mc, f3, z, l, lu)));
        @(posedge clk); #1;
        ex_valid = 1'b0;
        scramble();

        if (!mem || ill) begin
            @(negedge clk);
            chk("no_req", 32'(dmem_req), 32'd0);
            @(posedge clk); #1;
        end else begin
            for (int k = 0; k < C_TIMEOUT; k++) begin
                dmem_gnt    = (k == n_wait);
                dmem_rvalid = 1'($urandom);
                dmem_rdata  = $urandom;
                @(negedge clk);
                chk("req_high",  32'(dmem_req),  32'd1);
                chk("req_stall", 32'(mem_stall), 32'd1);
                chk("req_we",    32'(dmem_we),   32'(mc[2]));
                chk("req_addr",  dmem_addr,      {a[31:2], 2'b00});
                chk("req_be",    32'(dmem_be),   ld ? 32'hF : 32'(ref_be(f3, a)));
                if (!ld) chk("req_wdata", dmem_wdata, ref_wdata(f3, sd));
                @(posedge clk); #1;
                if (k == n_wait) break;
            end
            dmem_gnt    = 1'b0;
            dmem_rvalid = 1'b0;
            if (n_wait >= C_TIMEOUT) begin
                @(negedge clk);
                chk("tmo_req",   32'(dmem_req),  32'd0);
                chk("tmo_stall", 32'(mem_stall), 32'd0);
                @(posedge clk); #1;
            end else if (ld) begin
                for (int j = 0; j < C_TIMEOUT; j++) begin
                    dmem_rvalid = (j == r_wait);
                    dmem_rdata  = (j == r_wait) ? rdat : $urandom;
                    @(negedge clk);
                    chk("resp_req",   32'(dmem_req),  32'd0);
                    chk("resp_stall", 32'(mem_stall), 32'd1);
                    @(posedge clk); #1;
                    if (j == r_wait) break;
                end
                dmem_rvalid = 1'b0;
                if (r_wait >= C_TIMEOUT) begin
                    @(negedge clk);
                    chk("resp_tmo_stall", 32'(mem_stall), 32'd0);
                    @(posedge clk); #1;
                end
            end
        end
    endtask

    task automatic random_instr();
        logic [2:0]  mc;
        logic [2:0]  f3;
        logic [31:0] a;
        int          kind;
        int          nw;
        int          rw;
        kind = $urandom_range(0, 9);
        if (kind < 2)       mc = 3'b000;
        else if (kind < 4)  mc = 3'b001;
        else if (kind < 7)  mc = 3'b010;
        else if (kind < 9)  mc = 3'b100;
        else                mc = 3'($urandom);
        f3 = 3'($urandom);
        if ((mc[1] ^ mc[2]) && $urandom_range(0, 3) != 0) begin
            if (mc[1]) begin
                case ($urandom_range(0, 4))
                    0:       f3 = 3'd0;
                    1:       f3 = 3'd1;
                    2:       f3 = 3'd2;
                    3:       f3 = 3'd4;
                    default: f3 = 3'd5;
                endcase
            end else begin
                f3 = 3'($urandom_range(0, 2));
            end
        end
        a = $urandom;
        if ($urandom_range(0, 3) != 0) begin
            if (f3[1:0] == 2'd1) a[0] = 1'b0;
            if (f3[1:0] == 2'd2) a[1:0] = 2'd0;
        end
        nw = ($urandom_range(0, 4) == 0) ? C_TIMEOUT : $urandom_range(0, C_TIMEOUT - 1);
        rw = ($urandom_range(0, 9) == 0) ? C_TIMEOUT : $urandom_range(0, 2);
        issue(mc, f3, a, $urandom, 2'($urandom), 5'($urandom),
              1'($urandom), 1'($urandom), 1'($urandom), nw, rw, $urandom);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst         = 1'b1;
        ex_valid    = 1'b0;
        mem_ctrl    = 3'd0;
        funct3      = 3'd0;
        wb_ctrl_in  = 2'd0;
        alu_result  = 32'd0;
        store_data  = 32'd0;
        zero_in     = 1'b0;
        lt_in       = 1'b0;
        ltu_in      = 1'b0;
        rd_in       = 5'd0;
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata  = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("por");
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed: LB sign-extend, SH lane placement, misaligned LW, store timeout.
        issue(3'b010, 3'b000, 32'h0000_0103, 32'h1234_5678, 2'b11, 5'd7,
              1'b0, 1'b0, 1'b0, 0, 0, 32'h80FF_FFFF);
        issue(3'b100, 3'b001, 32'h0000_0202, 32'h0000_ABCD, 2'b01, 5'd9,
              1'b0, 1'b0, 1'b0, 2, 0, 32'h0);
        issue(3'b010, 3'b010, 32'h0000_0101, 32'h0, 2'b10, 5'd3,
              1'b0, 1'b0, 1'b0, 0, 0, 32'h0);
        issue(3'b100, 3'b010, 32'h0000_0300, 32'hDEAD_BEEF, 2'b01, 5'd4,
              1'b0, 1'b0, 1'b0, C_TIMEOUT, 0, 32'h0);
        issue(3'b010, 3'b101, 32'h0000_0402, 32'h0, 2'b10, 5'd5,
              1'b0, 1'b0, 1'b0, 1, C_TIMEOUT, 32'h0);

        // Branch sweep over every funct3 and flag combination.
        for (int f = 0; f < 8; f++) begin
            for (int fl = 0; fl < 8; fl++) begin
                issue(3'b001, 3'(f), $urandom, $urandom, 2'($urandom), 5'($urandom),
                      1'(fl >> 2), 1'(fl >> 1), 1'(fl), 0, 0, 32'h0);
            end
        end

        for (int n = 0; n < 250; n++) begin
            if ($urandom_range(0, 2) == 0) idle_cycle();
            random_instr();
        end

        // Reset while in RESP, then a stray rvalid.
        ex_valid   = 1'b1;
        mem_ctrl   = 3'b010;
        funct3     = 3'b010;
        alu_result = 32'h0000_0400;
        wb_ctrl_in = 2'b11;
        rd_in      = 5'd12;
        @(posedge clk); #1;
        ex_valid = 1'b0;
        dmem_gnt = 1'b1;
        @(posedge clk); #1;
        dmem_gnt = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        chk("pre_reset_resp_stall", 32'(mem_stall), 32'd1);
        @(posedge clk); #1;
        rst         = 1'b0;
        dmem_rvalid = 1'b1;
        dmem_rdata  = $urandom;
        @(negedge clk);
        check_reset_vals("mid_rst");
        @(posedge clk); #1;
        dmem_rvalid = 1'b0;
        @(negedge clk);
        check_reset_vals("stray_rvalid");
        @(posedge clk); #1;

        repeat (3) idle_cycle();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
